// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between the icache
// and dcache refill ports; one whole line burst is granted at a time.
module axi_rd_arbiter #(
  parameter int LINE_BEATS = 16,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rstn,
  // icache refill port
  input  logic        i_r_req,
  input  logic [31:0] i_r_addr,
  input  logic        i_r_data_ready,
  output logic        i_r_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_r_data,
  // dcache refill port
  input  logic        d_r_req,
  input  logic [31:0] d_r_addr,
  input  logic        d_r_data_ready,
  output logic        d_r_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_r_data,
  // AXI AR channel
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  // AXI R channel
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic [3:0]  rid,
  // status / debug
  output logic        rd_err,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  localparam logic [7:0]       ARLEN_C  = 8'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BEATS - 1);

  logic [1:0]       state;
  logic             owner;       // 0 = icache, 1 = dcache
  logic             last_grant;  // 0 = icache, 1 = dcache
  logic [CNT_W-1:0] beat_cnt;
  logic             grant_d;
  logic             ar_fire;
  logic             beat_fire;
  logic             err_evt;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and AR fields stay stable while
  // arvalid is high.
  assign grant_d   = d_r_req && (!i_r_req || !last_grant);
  assign ar_fire   = (state == ADDR) && arready;
  assign beat_fire = (state == DATA) && rvalid && rready;

  assign err_evt = (beat_fire && rlast && (beat_cnt != LAST_CNT)) ||
                   (beat_fire && (rid != arid)) ||
                   (rvalid && (state != DATA));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      araddr     <= 32'h0;
      arid       <= 4'h0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_r_req || d_r_req) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            araddr     <= grant_d ? d_r_addr : i_r_addr;
            arid       <= {3'b000, grant_d};
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (ar_fire) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (rlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky until reset; beats that trip it are still steered normally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        rd_err <= 1'b0;
    else if (err_evt) rd_err <= 1'b1;
  end

  always_comb begin
    arvalid     = (state == ADDR);
    arlen       = ARLEN_C;
    arsize      = 3'b010;
    arburst     = 2'b01;
    i_r_rdy     = ar_fire && !owner;
    d_r_rdy     = ar_fire && owner;
    rready      = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    i_r_data    = 32'h0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    d_r_data    = 32'h0;
    if (state == DATA) begin
      if (owner) begin
        rready      = d_r_data_ready;
        d_ret_valid = rvalid;
        d_ret_last  = rlast;
        d_r_data    = rdata;
      end else begin
        rready      = i_r_data_ready;
        i_ret_valid = rvalid;
        i_ret_last  = rlast;
        i_r_data    = rdata;
      end
    end
    state_dbg = state;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed grant/burst scenarios with a beat
// scoreboard fed as R beats are driven and drained as caches receive them.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_r_req, i_r_data_ready, i_r_rdy, i_ret_valid, i_ret_last;
  logic [31:0] i_r_addr, i_r_data;
  logic        d_r_req, d_r_data_ready, d_r_rdy, d_ret_valid, d_ret_last;
  logic [31:0] d_r_addr, d_r_data;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic        rd_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {owner_is_dcache, last, data}
  logic [31:0] cur_addr[2];

  axi_rd_arbiter #(.LINE_BEATS(16), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_data_ready(i_r_data_ready),
    .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .i_r_data(i_r_data),
    .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_data_ready(d_r_data_ready),
    .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .d_r_data(d_r_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid),
    .rd_err(rd_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    i_r_req = 1'b0; d_r_req = 1'b0;
    i_r_addr = 32'h0; d_r_addr = 32'h0;
    i_r_data_ready = 1'b1; d_r_data_ready = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rid = 4'h0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic pop_check(input logic who, input logic last, input logic [31:0] data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("beat_owner", 32'(who), 32'(e[33]));
      check("beat_last", 32'(last), 32'(e[32]));
      check("beat_data", data, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (i_ret_valid && i_r_data_ready) pop_check(1'b0, i_ret_last, i_r_data);
      if (d_ret_valid && d_r_data_ready) pop_check(1'b1, d_ret_last, d_r_data);
      if (i_r_rdy || d_r_rdy) check("rdy_has_ar", 32'(arvalid && arready), 1);
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic set_ready(input logic own_d, input logic v);
    if (own_d) d_r_data_ready = v;
    else       i_r_data_ready = v;
  endtask

  task automatic wait_ar(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!arvalid && n < 50);
    if (!arvalid) check("ar_timeout", 32'(arvalid), 1);
  endtask

  task automatic accept_ar(input logic own_d, input logic [31:0] exp_addr,
                           input int delay, input int exp_lat, input logic drop);
    int n;
    wait_ar(n);
    check("ar_latency", n, exp_lat);
    check("arid", 32'(arid), 32'(own_d));
    check("araddr", araddr, exp_addr);
    check("arlen", 32'(arlen), 15);
    check("arsize_burst", {27'h0, arsize, arburst}, {27'h0, 3'b010, 2'b01});
    repeat (delay) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("ar_hold", {araddr[31:1], arvalid}, {exp_addr[31:1], 1'b1});
    end
    @(posedge clk); #1;
    arready = 1'b1;
    @(negedge clk);
    check("r_rdy", {30'h0, i_r_rdy, d_r_rdy}, {30'h0, !own_d, own_d});
    @(posedge clk); #1;
    arready = 1'b0;
    if (drop) begin
      if (own_d) d_r_req = 1'b0;
      else       i_r_req = 1'b0;
    end
  endtask

  task automatic send_burst(input logic own_d, input int n, input int last_at,
                            input int stall_lo, input int stall_hi);
    for (int k = 0; k < n; k++) begin
      rvalid = 1'b1;
      rid    = {3'b000, own_d};
      rdata  = $urandom;
      rlast  = (k == last_at);
      if (k >= stall_lo && k <= stall_hi) begin
        set_ready(own_d, 1'b0);
        @(negedge clk);
        check("stall_rready", 32'(rready), 0);
        @(posedge clk); #1;
        set_ready(own_d, 1'b1);
      end
      exp_q.push_back({own_d, rlast, rdata});
      @(negedge clk);
      if (k == 0) check("rdy_pulse_off", 32'(i_r_rdy | d_r_rdy), 0);
      check("rready", 32'(rready), 1);
      if (own_d) check("nonowner_quiet", {i_r_data[31:1], i_ret_valid | i_ret_last}, 0);
      else       check("nonowner_quiet", {d_r_data[31:1], d_ret_valid | d_ret_last}, 0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rstn = 1'b0;
    i_r_req = 1'b0; d_r_req = 1'b0;
    i_r_addr = 32'h0; d_r_addr = 32'h0;
    i_r_data_ready = 1'b1; d_r_data_ready = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rid = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_araddr", araddr, 0);
    check("rst_arid", 32'(arid), 0);
    check("rst_const", {16'h0, arlen, 3'b000, arsize, arburst}, {16'h0, 8'd15, 3'b000, 3'b010, 2'b01});
    check("rst_outs", {24'h0, rready, rd_err, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, state_dbg}, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // single icache request, arready after 2 cycles
    @(posedge clk); #1;
    i_r_req = 1'b1; i_r_addr = 32'h1C00_0040;
    accept_ar(1'b0, 32'h1C00_0040, 2, 2, 1'b1);
    send_burst(1'b0, 16, 15, 99, 0);
    @(negedge clk);
    check("t1_idle", 32'(state_dbg), 0);
    check("t1_err", 32'(rd_err), 0);

    // simultaneous requests from reset: icache first, dcache next
    reset_dut();
    i_r_req = 1'b1; i_r_addr = 32'h0000_1000;
    d_r_req = 1'b1; d_r_addr = 32'h0000_2040;
    accept_ar(1'b0, 32'h0000_1000, 0, 2, 1'b1);
    send_burst(1'b0, 16, 15, 99, 0);
    accept_ar(1'b1, 32'h0000_2040, 1, 2, 1'b1);
    send_burst(1'b1, 16, 15, 99, 0);

    // dcache burst with its data_ready low for beats 3-5
    d_r_req = 1'b1; d_r_addr = 32'h8000_0100;
    accept_ar(1'b1, 32'h8000_0100, 0, 2, 1'b1);
    send_burst(1'b1, 16, 15, 2, 4);
    @(negedge clk);
    check("t3_err", 32'(rd_err), 0);

    // 100 back-to-back alternating bursts, both requests held high
    @(posedge clk); #1;
    cur_addr[0] = {$urandom_range(0, 32'hFFFF), 6'b0} ; cur_addr[1] = {$urandom_range(0, 32'hFFFF), 6'b0};
    i_r_addr = cur_addr[0]; d_r_addr = cur_addr[1];
    i_r_req = 1'b1; d_r_req = 1'b1;
    for (int b = 0; b < 100; b++) begin
      logic own;
      own = b[0];
      accept_ar(own, cur_addr[own], $urandom_range(0, 3), 2, b >= 98);
      cur_addr[own] = {$urandom_range(0, 32'hFFFF), 6'b0};
      if (own) d_r_addr = cur_addr[1];
      else     i_r_addr = cur_addr[0];
      send_burst(own, 16, 15, 99, 0);
    end
    @(negedge clk);
    check("alt_err", 32'(rd_err), 0);
    check("alt_idle", 32'(state_dbg), 0);

    // early rlast on beat 8 sets the sticky error
    @(posedge clk); #1;
    i_r_req = 1'b1; i_r_addr = 32'h0000_4000;
    accept_ar(1'b0, 32'h0000_4000, 0, 2, 1'b1);
    send_burst(1'b0, 8, 7, 99, 0);
    @(negedge clk);
    check("early_err", 32'(rd_err), 1);
    check("early_idle", 32'(state_dbg), 0);
    @(posedge clk); #1;
    d_r_req = 1'b1; d_r_addr = 32'h0000_4040;
    accept_ar(1'b1, 32'h0000_4040, 0, 2, 1'b1);
    send_burst(1'b1, 16, 15, 99, 0);
    @(negedge clk);
    check("err_sticky", 32'(rd_err), 1);

    // reset while beat 5 is on the bus
    @(posedge clk); #1;
    d_r_req = 1'b1; d_r_addr = 32'h0000_5000;
    accept_ar(1'b1, 32'h0000_5000, 0, 2, 1'b1);
    send_burst(1'b1, 4, 99, 99, 0);
    rvalid = 1'b1; rid = 4'h1; rdata = 32'hDEAD_BEEF; rlast = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_ar", {araddr[31:1], arvalid}, 0);
    check("mid_rst_r", {d_r_data[31:2], rready, d_ret_valid}, 0);
    check("mid_rst_state", {29'h0, rd_err, state_dbg}, 0);
    rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    d_r_req = 1'b1; d_r_addr = 32'h0000_6080;
    accept_ar(1'b1, 32'h0000_6080, 1, 2, 1'b1);
    send_burst(1'b1, 16, 15, 99, 0);
    @(negedge clk);
    check("post_rst_err", 32'(rd_err), 0);
    check("post_rst_idle", 32'(state_dbg), 0);

    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
